line_serializer: RTL

LINE_SERIALIZER -- requirements
Module: line_serializer

---
 rtl/line_serializer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/line_serializer.sv
// line_serializer: collects LENGTH column tuples (three vertically aligned
// pixels) into three line RAMs, then replays them as a raster stream:
// line 0, then line 1, then line 2, with a valid/ready handshake on each side.
module line_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int LENGTH     = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_line,
  output logic                  out_last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LENGTH - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                state, state_next;
  logic                  in_ready_r;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [1:0]            rd_line;
  logic                  rd_done;

  logic [DATA_WIDTH-1:0] mem0 [LENGTH];
  logic [DATA_WIDTH-1:0] mem1 [LENGTH];
  logic [DATA_WIDTH-1:0] mem2 [LENGTH];

  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [1:0]            line_p0;
  logic                  last_p0;

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [1:0]            line_p1;
  logic                  last_p1;

  logic                  skid_vld;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [1:0]            skid_line;
  logic                  skid_last;

  logic       accept, last_col, pop, final_pop, issue, load_slot, skid_load;
  logic [1:0] occ;

  // Handshake decode plus read-issue credit: a read may only be launched
  // when the slot+skid pair is guaranteed room for it one cycle later.
  always_comb begin
    accept    = in_valid && in_ready_r;
    last_col  = accept && (wr_addr == LAST_ADDR);
    pop       = vld_p1 && out_ready;
    final_pop = pop && (line_p1 == 2'd2) && last_p1;
    occ       = 2'(vld_p0) + 2'(vld_p1) + 2'(skid_vld);
    issue     = (state == DRAIN) && !rd_done && ((occ - 2'(pop)) < 2'd2);
    load_slot = !vld_p1 || pop;
    skid_load = vld_p0 && (skid_vld ? load_slot : !load_slot);
  end

  // Next-state logic: FILL until the last column lands, DRAIN until the
  // final beat of line 2 is taken downstream.
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (last_col)  state_next = DRAIN;
      DRAIN:   if (final_pop) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // State register; in_ready is registered so it stays low for the cycle
  // after reset and after the final column.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      in_ready_r <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready_r <= (state_next == FILL);
    end
  end

  assign in_ready = in_ready_r;

  // Write pointer walks 0..LENGTH-1 once per fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
    end else if (accept) begin
      wr_addr <= last_col ? '0 : wr_addr + 1'b1;
    end
  end

  // Line RAM writes; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem0[wr_addr] <= data_in_0;
      mem1[wr_addr] <= data_in_1;
      mem2[wr_addr] <= data_in_2;
    end
  end

  // Read pointer: addr-major inside a line, line-major overall.
  always_ff @(posedge clk) begin
    if (rst || final_pop) begin
      rd_addr <= '0;
      rd_line <= 2'd0;
      rd_done <= 1'b0;
    end else if (issue) begin
      if (rd_addr == LAST_ADDR) begin
        rd_addr <= '0;
        if (rd_line == 2'd2) begin
          rd_line <= 2'd0;
          rd_done <= 1'b1;
        end else begin
          rd_line <= rd_line + 2'd1;
        end
      end else begin
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  // ---- stage p0: RAM read data ----
  // Read-valid tracks issued reads.
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= issue;
  end

  // Read data with its line tag and end-of-line flag.
  always_ff @(posedge clk) begin
    if (issue) begin
      case (rd_line)
        2'd0:    data_p0 <= mem0[rd_addr];
        2'd1:    data_p0 <= mem1[rd_addr];
        default: data_p0 <= mem2[rd_addr];
      endcase
      line_p0 <= rd_line;
      last_p0 <= (rd_addr == LAST_ADDR);
    end
  end

  // ---- stage p1: output slot and skid ----
  // Output slot refills from the skid first (older beat), else from p0.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      skid_vld <= 1'b0;
      data_p1  <= '0;
      line_p1  <= 2'd0;
      last_p1  <= 1'b0;
    end else if (load_slot) begin
      if (skid_vld) begin
        vld_p1   <= 1'b1;
        data_p1  <= skid_data;
        line_p1  <= skid_line;
        last_p1  <= skid_last;
        skid_vld <= vld_p0;
      end else if (vld_p0) begin
        vld_p1  <= 1'b1;
        data_p1 <= data_p0;
        line_p1 <= line_p0;
        last_p1 <= last_p0;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (vld_p0) begin
      skid_vld <= 1'b1;
    end
  end

  // Skid payload captures a p0 beat that cannot go straight to the slot.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_data <= data_p0;
      skid_line <= line_p0;
      skid_last <= last_p0;
    end
  end

  assign out_valid = vld_p1;
  assign data_out  = data_p1;
  assign out_line  = line_p1;
  assign out_last  = last_p1;

endmodule
